// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch slice.
//   XLEN          : datapath / address width
//   PC_STEP       : byte increment between sequential fetches
//   fetch_state_e : fetch sequencer states
//                   IDLE - may issue a request
//                   WAIT - request accepted, response pending
//                   DROP - response pending but belongs to a flushed stream
//   fetch_entry_t : one buffered instruction with the PC it was fetched from
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
// Bundles the two handshakes of the fetch unit.
//   Instruction memory side : imem_req/imem_addr (to memory),
//                             imem_gnt/imem_rvalid/imem_rdata (from memory)
//   Decode side             : out_valid/out_instr/out_pc (to decode),
//                             out_ready (from decode)
// Modports:
//   master - the fetch unit
//   slave  - the environment (instruction memory plus decode stage)
// ---------------------------------------------------------------------------
interface fetch_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   logic            out_valid;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic            out_ready;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc,
      output imem_gnt, imem_rvalid, imem_rdata, out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry synchronous FIFO of {instr, pc} entries between fetch and decode.
//   clk, rst    : clock, synchronous active-low reset
//   flush       : empties the FIFO; dominates push and pop in the same cycle
//   push        : write push_data at the tail (caller guarantees a free slot)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored while empty)
//   count       : number of valid entries, 0..DEPTH
//   head_valid  : FIFO not empty
//   head        : head entry, all-zero while empty
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output logic [CW-1:0] count,
   output logic         head_valid,
   output fetch_entry_t head
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign head_valid = (count != '0);
   assign do_pop     = pop && head_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !do_pop)      count <= count + CW'(1);
         else if (!push && do_pop) count <= count - CW'(1);
      end
   end

   // NOTE: the storage array is deliberately not reset; only the pointers
   // and count are, and the head is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch sequencer. Holds the fetch PC, issues one word request at
// a time to instruction memory (req/gnt/rvalid), and buffers returned
// instructions with their PCs toward decode. A redirect flushes buffered and
// in-flight fetches and restarts fetching at the target.
//   clk, rst     : clock, synchronous active-low reset
//   bus          : fetch_if.master (imem request/response and decode output)
//   redirect     : taken branch/jump, load redirect_pc this cycle
//   redirect_pc  : redirect target
//   misalign     : misaligned-redirect trap flag
// Parameters: RESET_PC (fetch PC after reset), DEPTH (FIFO entries, pow2 >= 2)
// Optional feature macro FETCH_MISALIGN_TRAP_EN:
//   defined   - a misaligned redirect raises misalign and halts fetching until
//               the next aligned redirect or reset
//   undefined - redirect_pc[1:0] is forced to zero and misalign is tied low
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   fetch_if.master         bus,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            misalign
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e    state;
   fetch_state_e    next_state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0]   count;
   logic            halt;
   logic            grant;
   logic            push;
   logic            pop;
   logic            head_valid;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

`ifdef FETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst)          halt <= 1'b0;
      else if (redirect) halt <= (redirect_pc[1:0] != 2'b00);
   end
   assign target_pc = redirect_pc;
`else
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign halt      = 1'b0;
   assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};
`endif

   assign misalign = halt;

   // Credit rule: only request when the FIFO can absorb the response.
   assign bus.imem_req  = (state == IDLE) && rst && !halt && (count < CW'(DEPTH));
   assign bus.imem_addr = pc;
   assign grant         = bus.imem_req && bus.imem_gnt;

   // A redirect flushes the FIFO, so push and pop in that cycle are void.
   assign push       = (state == WAIT) && bus.imem_rvalid && !redirect;
   assign pop        = head_valid && bus.out_ready && !redirect;
   assign push_entry = '{instr: bus.imem_rdata, pc: req_pc};

   // NOTE: next_state gets a default before any branch so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (grant)            next_state = WAIT;
         WAIT:    if (bus.imem_rvalid)  next_state = IDLE;
         DROP:    if (bus.imem_rvalid)  next_state = IDLE;
         default:                       next_state = IDLE;
      endcase
      // Any request still unanswered after a redirect belongs to the old
      // stream; its response must be swallowed in DROP.
      if (redirect) begin
         if (((state != IDLE) && !bus.imem_rvalid) || grant) next_state = DROP;
         else                                               next_state = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
      end else begin
         state <= next_state;
         if (redirect) begin
            pc <= target_pc;
         end else if (grant) begin
            pc     <= pc + PC_STEP;
            req_pc <= pc;
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .push       (push),
      .push_data  (push_entry),
      .pop        (pop),
      .count      (count),
      .head_valid (head_valid),
      .head       (head)
   );

   assign bus.out_valid = head_valid;
   assign bus.out_instr = head.instr;
   assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. The bench plays instruction memory
// (random grant, random response latency, one outstanding request) and the
// decode stage (random out_ready), and compares the DUT every cycle with a
// transaction-level model: the next address to fetch, the next PC decode
// should see, FIFO occupancy and whether the outstanding response is live.
// Instruction words are a fixed function of their address, so each popped
// entry proves the instr/pc pairing. Honours FETCH_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        misalign;

   fetch_if bus ();

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .misalign    (misalign)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // stimulus knobs
   int gnt_pct  = 100;
   int rdy_pct  = 100;
   int lat_max  = 0;
   bit nop_mode = 1'b1;

   // reference model
   logic [31:0] m_fetch_pc;
   logic [31:0] m_pop_pc;
   int          m_count;
   bit          m_busy;
   bit          m_live;
   bit          m_halt;

   // memory side
   bit          mem_pending = 1'b0;
   int          mem_lat     = 0;
   logic [31:0] mem_addr    = '0;

   int pops_seen;
   bit wrap_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (nop_mode) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_0013;
   endfunction

   // One clock cycle: compare, drive inputs, advance model and memory.
   task automatic step(input bit redir, input logic [31:0] rpc);
      bit exp_req, exp_valid, pop, gnt_now, rv;
      @(negedge clk);
      exp_req   = !m_busy && (m_count < DEPTH) && !m_halt;
      exp_valid = (m_count > 0);
      check("imem_req", bus.imem_req, exp_req);
      if (exp_req && bus.imem_req) check("imem_addr", bus.imem_addr, m_fetch_pc);
      check("out_valid", bus.out_valid, exp_valid);
      if (exp_valid && bus.out_valid) begin
         check("out_pc", bus.out_pc, m_pop_pc);
         check("out_instr", bus.out_instr, mem_fn(m_pop_pc));
      end
      check("misalign", misalign, m_halt);

      rv      = mem_pending && (mem_lat == 0);
      gnt_now = !mem_pending && ($urandom_range(0, 99) < gnt_pct);
      bus.imem_gnt    = gnt_now;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? mem_fn(mem_addr) : $urandom;
      bus.out_ready   = ($urandom_range(0, 99) < rdy_pct);
      redirect        = redir;
      redirect_pc     = rpc;

      if (bus.out_valid && bus.out_ready) pops_seen++;
      if (bus.imem_req && gnt_now && bus.imem_addr == 32'h0 && !redir) wrap_seen = 1'b1;

      pop = exp_valid && bus.out_ready;
      if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         m_halt     = (rpc[1:0] != 2'b00);
         m_fetch_pc = rpc;
`else
         m_fetch_pc = {rpc[31:2], 2'b00};
`endif
         m_pop_pc = m_fetch_pc;
         m_count  = 0;
         if (m_busy) begin
            if (rv) m_busy = 1'b0;
            else    m_live = 1'b0;
         end else if (exp_req && gnt_now) begin
            m_busy = 1'b1;
            m_live = 1'b0;
         end
      end else begin
         if (m_busy && rv) begin
            if (m_live) m_count++;
            m_busy = 1'b0;
         end
         if (exp_req && gnt_now) begin
            m_busy     = 1'b1;
            m_live     = 1'b1;
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
         if (pop) begin
            m_count--;
            m_pop_pc = m_pop_pc + 32'd4;
         end
      end

      if (rv) mem_pending = 1'b0;
      else if (mem_pending) mem_lat--;
      if (bus.imem_req && gnt_now) begin
         mem_pending = 1'b1;
         mem_addr    = bus.imem_addr;
         mem_lat     = $urandom_range(0, lat_max);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst             = 1'b0;
      redirect        = 1'b0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.out_ready   = 1'b0;
      repeat (cycles) @(negedge clk);
      check("rst_req", bus.imem_req, 1'b0);
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_out_pc", bus.out_pc, 32'h0);
      check("rst_out_instr", bus.out_instr, 32'h0);
      check("rst_misalign", misalign, 1'b0);
      m_fetch_pc = RESET_PC;
      m_pop_pc   = RESET_PC;
      m_count    = 0;
      m_busy     = 1'b0;
      m_live     = 1'b0;
      m_halt     = 1'b0;
      rst        = 1'b1;
      #1;
      check("first_req", bus.imem_req, 1'b1);
      check("first_addr", bus.imem_addr, RESET_PC);
   endtask

   task automatic drain();
      gnt_pct = 0;
      for (int i = 0; i < 10 && mem_pending; i++) step(1'b0, 32'h0);
   endtask

   initial begin
      bit found;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.out_ready   = 1'b0;

      // Streaming NOPs, gnt same cycle, rvalid next cycle.
      nop_mode = 1'b1; gnt_pct = 100; rdy_pct = 100; lat_max = 0;
      do_reset(2);
      pops_seen = 0;
      repeat (40) step(1'b0, 32'h0);
      check("throughput_pops", pops_seen, 19);

      // Back-pressure: FIFO fills, requests stop, then resume without loss.
      do_reset(1);
      nop_mode = 1'b0;
      rdy_pct = 0;
      repeat (10) step(1'b0, 32'h0);
      check("full_valid", bus.out_valid, 1'b1);
      check("full_req_blocked", bus.imem_req, 1'b0);
      rdy_pct = 100;
      repeat (20) step(1'b0, 32'h0);

      // Redirect to 0x100 while a fetch is in flight.
      lat_max = 3;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (m_busy && mem_pending && mem_lat >= 1) found = 1'b1;
         else step(1'b0, 32'h0);
      end
      check("inflight_found", found, 1'b1);
      step(1'b1, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 32'h0);
         if (bus.imem_req) found = 1'b1;
      end
      check("redirect_first_req", found, 1'b1);
      check("redirect_first_addr", bus.imem_addr, 32'h100);
      repeat (10) step(1'b0, 32'h0);

      // Redirect in the same cycle as rvalid and a pop.
      lat_max = 0; gnt_pct = 100; rdy_pct = 30;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (m_busy && mem_pending && mem_lat == 0 && m_count > 0) found = 1'b1;
         else step(1'b0, 32'h0);
      end
      check("collide_found", found, 1'b1);
      rdy_pct = 100;
      step(1'b1, 32'h300);
      step(1'b0, 32'h0);
      check("collide_flushed", bus.out_valid, 1'b0);
      repeat (8) step(1'b0, 32'h0);

      // PC wrap at the top of the address space.
      drain();
      wrap_seen = 1'b0;
      step(1'b1, 32'hFFFF_FFF8);
      gnt_pct = 100; lat_max = 0;
      repeat (12) step(1'b0, 32'h0);
      check("wrap_to_zero", wrap_seen, 1'b1);

      // Misaligned redirect.
      drain();
      step(1'b1, 32'h102);
      step(1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("trap_misalign", misalign, 1'b1);
      check("trap_no_req", bus.imem_req, 1'b0);
      gnt_pct = 100;
      repeat (4) step(1'b0, 32'h0);
      step(1'b1, 32'h200);
      step(1'b0, 32'h0);
      check("trap_cleared", misalign, 1'b0);
      check("trap_resume_addr", bus.imem_addr, 32'h200);
`else
      check("aligned_req", bus.imem_req, 1'b1);
      check("aligned_addr", bus.imem_addr, 32'h100);
      gnt_pct = 100;
`endif
      repeat (10) step(1'b0, 32'h0);

      // Random traffic with redirects and one mid-operation reset.
      gnt_pct = 70; rdy_pct = 60; lat_max = 2;
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) begin
            do_reset(2);
         end else if ($urandom_range(0, 99) < 5) begin
            logic [31:0] t;
            t = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0) t = t | 32'h2;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
            step(1'b1, t);
         end else begin
            step(1'b0, 32'h0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer at the front of the CPU pipeline; it consumes the branch/jump redirect (`load` + target PC) produced by the execute-stage address builder. It keeps the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake with at most one request outstanding, and buffers returned instructions with their PCs in a small FIFO toward decode. On redirect it flushes buffered and in-flight fetches and restarts at the target.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch PC loaded by reset
- `DEPTH`, 2, instruction FIFO entries (power of two, ≥2)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `redirect`  in  1  taken branch/jump; load `redirect_pc` this cycle
- `redirect_pc`  in  32  redirect target
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  word address of request (bits[1:0]=0)
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response for the outstanding request
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`
- `out_valid`  out  1  FIFO head valid
- `out_instr`  out  32  head instruction
- `out_pc`  out  32  PC of head instruction
- `out_ready`  in  1  decode accepts head (pop when `out_valid && out_ready`)
- `misalign`  out  1  misaligned redirect trap (only with macro, else tied 0)

## Operation
- Reset values: pc=`RESET_PC`, state IDLE, FIFO empty, `out_valid`=0, `imem_req`=0, `misalign`=0; `out_instr`/`out_pc` 0.
- States: IDLE (may request), WAIT (request in flight), DROP (in-flight response to be discarded).
- `imem_req` = state==IDLE && rst && !halt && (count + 0) < DEPTH; combinational from registers; `imem_addr`=pc.
- IDLE & gnt: pc←pc+4 (wraps mod 2^32), record request PC, →WAIT.
- WAIT & rvalid: push {rdata, request PC}, →IDLE. Credit rule guarantees a free slot; push never overflows.
- DROP & rvalid: discard, →IDLE.
- redirect (priority over all other events): pc←redirect_pc; FIFO emptied (pop/push this cycle ignored); if WAIT without rvalid this cycle, or IDLE with gnt this cycle → DROP; else → IDLE. Response arriving in the redirect cycle is discarded.
- Redirect while in DROP: stay DROP, pc updated.
- Simultaneous push and pop: both take effect, count unchanged.
- `out_ready` while `out_valid`=0: no effect.

## Timing
- Reset deasserted at cycle 0 → first `imem_req` at cycle 0 with `RESET_PC` (combinational from reset state).
- rvalid at cycle M → `out_valid` at M+1 (registered FIFO write).
- Redirect at cycle N, no fetch in flight → `imem_req` with target at N+1; `out_valid`=0 from N+1.
- Redirect at N with fetch in flight → request at cycle after the dropped rvalid.
- Steady state with gnt same cycle and rvalid next cycle: one instruction per 2 cycles.
- Reset mid-operation: returns to reset values next edge; a late rvalid after reset is ignored (state IDLE).

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: redirect with `redirect_pc[1:0]`≠0 sets `misalign`=1 and halt (no requests, FIFO flushed) until next aligned redirect or reset; aligned redirect clears both.
- Undefined: `redirect_pc[1:0]` forced to 0; `misalign` tied 0; no halt logic.

## Structure
- Package `fetch_pkg`: state enum (IDLE/WAIT/DROP), `XLEN`=32, `PC_STEP`=4, FIFO entry struct {instr, pc}.
- Sub-module `fetch_fifo`: DEPTH-entry sync FIFO with push/pop/flush, count, head outputs.

## Test plan
- Reset, gnt=1, rvalid next cycle, rdata=0x00000013 → `out_pc` 0,4,8 with `out_instr` 0x13, one push per 2 cycles.
- `out_ready`=0 → FIFO fills to DEPTH=2, `imem_req` drops; raise `out_ready` → requests resume, no loss.
- Redirect to 0x100 while WAIT → first rvalid discarded, next `imem_addr`=0x100, `out_pc`=0x100.
- Redirect same cycle as rvalid and as push/pop → FIFO empty next cycle, rdata dropped.
- pc=0xFFFF_FFFC granted → next `imem_addr`=0x0000_0000.
- Macro on: redirect 0x102 → `misalign`=1, no `imem_req`; redirect 0x200 → clears, fetch 0x200. Macro off: 0x102 fetches 0x100.
